// File: rtl/mmu_seq_ctrl.sv
// mmu_seq_ctrl -- job sequencer for the weight-stationary systolic MMU.
//
// A job loads SIZE weight rows into the array (mmu_control=1), streams
// num_vec input vectors with per-lane diagonal skew (mmu_control=0), then
// flags the cycles on which the MMU acc_out carries results.
//
// Ports:
//   i_clk, i_rst           clock (rising edge), asynchronous active-high reset
//   i_start, i_num_vec     job request and vector count (sampled in IDLE)
//   i_wt_reuse             skip the weight load if weights are already resident
//                          (present only when MMU_SEQ_WT_REUSE_EN is defined)
//   o_busy, o_done         job in progress, one-cycle completion pulse
//   o_wt_rd_*, i_wt_rd_data  weight-buffer read port (1-cycle latency)
//   o_in_rd_*, i_in_rd_data  input-buffer read port (1-cycle latency)
//   o_mmu_control, o_mmu_wt_arr, o_mmu_data_arr   MMU drive
//   o_out_valid, o_out_idx   result-valid flag and owning vector index
//
// Configuration macro: MMU_SEQ_WT_REUSE_EN (weight-reuse option).

module mmu_seq_ctrl #(
   parameter int SIZE      = 4,
   parameter int BIT_WIDTH = 8,
   parameter int ARR_WIDTH = SIZE*BIT_WIDTH,
   parameter int VEC_W     = 8,
   parameter int OUT_LAT   = 2*SIZE
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic                     i_start,
   input  logic [VEC_W-1:0]         i_num_vec,
`ifdef MMU_SEQ_WT_REUSE_EN
   input  logic                     i_wt_reuse,
`endif
   output logic                     o_busy,
   output logic                     o_done,
   output logic                     o_wt_rd_en,
   output logic [$clog2(SIZE)-1:0]  o_wt_rd_addr,
   input  logic [ARR_WIDTH-1:0]     i_wt_rd_data,
   output logic                     o_in_rd_en,
   output logic [VEC_W-1:0]         o_in_rd_addr,
   input  logic [ARR_WIDTH-1:0]     i_in_rd_data,
   output logic                     o_mmu_control,
   output logic [ARR_WIDTH-1:0]     o_mmu_wt_arr,
   output logic [ARR_WIDTH-1:0]     o_mmu_data_arr,
   output logic                     o_out_valid,
   output logic [VEC_W-1:0]         o_out_idx
);

   localparam int AW = $clog2(SIZE);
   // Counter covers the longest job: OUT_LAT + (2^VEC_W-1) + 1 cycles of FEED/DRAIN.
   localparam int CW = VEC_W + $clog2(OUT_LAT + SIZE) + 1;
   localparam logic [CW-1:0] C_LAST_ROW = CW'(SIZE-1);
   localparam logic [CW-1:0] C_FLUSH    = CW'(SIZE-1);
   localparam logic [CW-1:0] C_LAT      = CW'(OUT_LAT);

   typedef enum logic [1:0] {S_IDLE, S_LOAD_WT, S_FEED, S_DRAIN} state_t;

   state_t           r_state, w_state_nxt;
   logic [CW-1:0]    r_cnt, w_cnt_nxt, w_cnt_inc, w_nv_ext;
   logic [VEC_W-1:0] r_num_vec, w_num_vec_nxt;
   logic             r_busy, w_busy_nxt;
   logic             r_done, w_done_nxt;
   logic             r_wt_rd_en, w_wt_rd_en_nxt;
   logic [AW-1:0]    r_wt_rd_addr, w_wt_rd_addr_nxt;
   logic             r_in_rd_en, w_in_rd_en_nxt;
   logic [VEC_W-1:0] r_in_rd_addr, w_in_rd_addr_nxt;
   logic             r_out_valid, w_out_valid_nxt;
   logic [VEC_W-1:0] r_out_idx, w_out_idx_nxt;
   logic             r_wt_beat;   // buffer data of a weight read is on i_wt_rd_data
   logic             r_in_vld;    // buffer data of a vector read is on i_in_rd_data
   logic             w_skip_load;

`ifdef MMU_SEQ_WT_REUSE_EN
   logic r_wt_loaded, w_wt_loaded_nxt;
   assign w_skip_load = i_wt_reuse && r_wt_loaded;
`else
   assign w_skip_load = 1'b0;
`endif

   assign w_cnt_inc = r_cnt + CW'(1);
   assign w_nv_ext  = CW'(r_num_vec);

   // FEED/DRAIN share one counter: count k is cycle F0-1+k, so read k+1 is
   // issued for the next cycle and result v lands at count OUT_LAT+1+v.
   always_comb begin
      w_state_nxt      = r_state;
      w_cnt_nxt        = w_cnt_inc;
      w_num_vec_nxt    = r_num_vec;
      w_busy_nxt       = r_busy;
      w_done_nxt       = 1'b0;
      w_wt_rd_en_nxt   = 1'b0;
      w_wt_rd_addr_nxt = '0;
      w_in_rd_en_nxt   = 1'b0;
      w_in_rd_addr_nxt = '0;
      w_out_valid_nxt  = 1'b0;
      w_out_idx_nxt    = '0;
`ifdef MMU_SEQ_WT_REUSE_EN
      w_wt_loaded_nxt  = r_wt_loaded;
`endif
      case (r_state)
         S_IDLE: begin
            w_cnt_nxt  = '0;
            w_busy_nxt = 1'b0;
            if (i_start && (i_num_vec != '0)) begin
               w_num_vec_nxt = i_num_vec;
               w_busy_nxt    = 1'b1;
               if (w_skip_load) begin
                  w_state_nxt    = S_FEED;
                  w_in_rd_en_nxt = 1'b1;
               end else begin
                  w_state_nxt    = S_LOAD_WT;
                  w_wt_rd_en_nxt = 1'b1;
               end
            end
         end
         S_LOAD_WT: begin
            if (r_cnt == C_LAST_ROW) begin
               w_state_nxt    = S_FEED;
               w_cnt_nxt      = '0;
               w_in_rd_en_nxt = 1'b1;
`ifdef MMU_SEQ_WT_REUSE_EN
               w_wt_loaded_nxt = 1'b1;
`endif
            end else begin
               w_wt_rd_en_nxt   = 1'b1;
               w_wt_rd_addr_nxt = AW'(w_cnt_inc);
            end
         end
         S_FEED, S_DRAIN: begin
            if (r_done) begin
               w_state_nxt = S_IDLE;
               w_busy_nxt  = 1'b0;
               w_cnt_nxt   = '0;
            end else begin
               w_in_rd_en_nxt   = (w_cnt_inc < w_nv_ext);
               w_in_rd_addr_nxt = w_in_rd_en_nxt ? VEC_W'(w_cnt_inc) : '0;
               w_out_valid_nxt  = (r_cnt >= C_LAT) && (r_cnt < C_LAT + w_nv_ext);
               w_out_idx_nxt    = w_out_valid_nxt ? VEC_W'(r_cnt - C_LAT) : '0;
               w_done_nxt       = (r_cnt == C_LAT + w_nv_ext);
               // Feed window is num_vec+SIZE-1 cycles starting at F0.
               if ((r_state == S_FEED) && (r_cnt == w_nv_ext + C_FLUSH))
                  w_state_nxt = S_DRAIN;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_busy_nxt  = 1'b0;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state      <= S_IDLE;
         r_cnt        <= '0;
         r_num_vec    <= '0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_wt_rd_en   <= 1'b0;
         r_wt_rd_addr <= '0;
         r_in_rd_en   <= 1'b0;
         r_in_rd_addr <= '0;
         r_out_valid  <= 1'b0;
         r_out_idx    <= '0;
         r_wt_beat    <= 1'b0;
         r_in_vld     <= 1'b0;
`ifdef MMU_SEQ_WT_REUSE_EN
         r_wt_loaded  <= 1'b0;
`endif
      end else begin
         r_state      <= w_state_nxt;
         r_cnt        <= w_cnt_nxt;
         r_num_vec    <= w_num_vec_nxt;
         r_busy       <= w_busy_nxt;
         r_done       <= w_done_nxt;
         r_wt_rd_en   <= w_wt_rd_en_nxt;
         r_wt_rd_addr <= w_wt_rd_addr_nxt;
         r_in_rd_en   <= w_in_rd_en_nxt;
         r_in_rd_addr <= w_in_rd_addr_nxt;
         r_out_valid  <= w_out_valid_nxt;
         r_out_idx    <= w_out_idx_nxt;
         r_wt_beat    <= r_wt_rd_en;
         r_in_vld     <= r_in_rd_en;
`ifdef MMU_SEQ_WT_REUSE_EN
         r_wt_loaded  <= w_wt_loaded_nxt;
`endif
      end
   end

   // Buffer read data comes straight from the buffers' output registers;
   // it is only gated here so the MMU sees zeros outside valid beats.
   logic [SIZE-1:0][BIT_WIDTH-1:0] w_lane_in, w_lane_out;
   assign w_lane_in     = r_in_vld ? i_in_rd_data : '0;
   assign w_lane_out[0] = w_lane_in[0];

   // Lane j is delayed by j registers to form the diagonal wavefront.
   for (genvar j = 1; j < SIZE; j++) begin : g_skew
      logic [j-1:0][BIT_WIDTH-1:0] r_dly;
      always_ff @(posedge i_clk or posedge i_rst) begin
         if (i_rst) begin
            r_dly <= '0;
         end else begin
            r_dly[0] <= w_lane_in[j];
            for (int k = 1; k < j; k++) r_dly[k] <= r_dly[k-1];
         end
      end
      assign w_lane_out[j] = r_dly[j-1];
   end

   assign o_busy         = r_busy;
   assign o_done         = r_done;
   assign o_wt_rd_en     = r_wt_rd_en;
   assign o_wt_rd_addr   = r_wt_rd_addr;
   assign o_in_rd_en     = r_in_rd_en;
   assign o_in_rd_addr   = r_in_rd_addr;
   assign o_mmu_control  = r_wt_beat;
   assign o_mmu_wt_arr   = r_wt_beat ? i_wt_rd_data : '0;
   assign o_mmu_data_arr = w_lane_out;
   assign o_out_valid    = r_out_valid;
   assign o_out_idx      = r_out_idx;

endmodule

// File: tb/tb_mmu_seq_ctrl.sv
// Scoreboard bench for mmu_seq_ctrl. Each job pushes its expected weight
// beats, skewed feed rows, result indices, done cycle and busy window
// (derived from the job's timing rules) into queues; a negedge monitor
// pops and compares as the DUT presents them.

module tb_mmu_seq_ctrl;
   localparam int SIZE    = 4;
   localparam int BW      = 8;
   localparam int AWID    = SIZE*BW;
   localparam int VEC_W   = 8;
   localparam int OUT_LAT = 2*SIZE;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start = 1'b0;
   logic [VEC_W-1:0] num_vec = '0;
`ifdef MMU_SEQ_WT_REUSE_EN
   logic wt_reuse = 1'b0;
`endif
   logic busy, done, wt_rd_en, in_rd_en, mmu_control, out_valid;
   logic [$clog2(SIZE)-1:0] wt_rd_addr;
   logic [VEC_W-1:0] in_rd_addr, out_idx;
   logic [AWID-1:0] wt_rd_data = '0, in_rd_data = '0, mmu_wt_arr, mmu_data_arr;

   mmu_seq_ctrl #(.SIZE(SIZE), .BIT_WIDTH(BW), .VEC_W(VEC_W)) dut (
      .i_clk(clk), .i_rst(rst), .i_start(start), .i_num_vec(num_vec),
`ifdef MMU_SEQ_WT_REUSE_EN
      .i_wt_reuse(wt_reuse),
`endif
      .o_busy(busy), .o_done(done),
      .o_wt_rd_en(wt_rd_en), .o_wt_rd_addr(wt_rd_addr), .i_wt_rd_data(wt_rd_data),
      .o_in_rd_en(in_rd_en), .o_in_rd_addr(in_rd_addr), .i_in_rd_data(in_rd_data),
      .o_mmu_control(mmu_control), .o_mmu_wt_arr(mmu_wt_arr), .o_mmu_data_arr(mmu_data_arr),
      .o_out_valid(out_valid), .o_out_idx(out_idx)
   );

   always #5 clk = ~clk;

   // Synchronous-read buffers, one cycle of latency, output held otherwise.
   logic [AWID-1:0] wt_mem [SIZE];
   logic [AWID-1:0] in_mem [256];
   always @(posedge clk) begin
      if (wt_rd_en) wt_rd_data <= wt_mem[wt_rd_addr];
      if (in_rd_en) in_rd_data <= in_mem[in_rd_addr];
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct { int c; logic [63:0] v; } ev_t;
   ev_t q_wt[$], q_dat[$], q_out[$], q_done[$];
   bit  exp_busy [int];
   bit  model_loaded = 1'b0;
   int  n_checks = 0, n_errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
      end
   endtask

   always @(negedge clk) begin
      ev_t ev;
      if (rst) begin
         chk("rst_ctrl", {busy, done, wt_rd_en, in_rd_en, mmu_control, out_valid}, '0);
         chk("rst_addr", {wt_rd_addr, in_rd_addr, out_idx}, '0);
         chk("rst_wt_arr", mmu_wt_arr, '0);
         chk("rst_data_arr", mmu_data_arr, '0);
      end else begin
         chk("busy", busy, exp_busy.exists(cyc));
         if (q_wt.size() > 0 && q_wt[0].c == cyc) begin
            ev = q_wt.pop_front();
            chk("wt_control", mmu_control, 1);
            chk("wt_row", mmu_wt_arr, ev.v);
         end else begin
            chk("control_idle", mmu_control, 0);
            chk("wt_arr_idle", mmu_wt_arr, 0);
         end
         if (q_dat.size() > 0 && q_dat[0].c == cyc) begin
            ev = q_dat.pop_front();
            chk("data_row", mmu_data_arr, ev.v);
         end else begin
            chk("data_idle", mmu_data_arr, 0);
         end
         while (q_out.size() > 0 && q_out[0].c < cyc) begin
            ev = q_out.pop_front();
            chk("out_valid_missed_cycle", cyc, ev.c);
         end
         if (out_valid) begin
            if (q_out.size() == 0) chk("out_valid_unexpected", out_valid, 0);
            else begin
               ev = q_out.pop_front();
               chk("out_valid_cycle", cyc, ev.c);
               chk("out_idx", out_idx, ev.v);
            end
         end
         while (q_done.size() > 0 && q_done[0].c < cyc) begin
            ev = q_done.pop_front();
            chk("done_missed_cycle", cyc, ev.c);
         end
         if (done) begin
            if (q_done.size() == 0) chk("done_unexpected", done, 0);
            else begin
               ev = q_done.pop_front();
               chk("done_cycle", cyc, ev.c);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic fill_mem();
      for (int r = 0; r < SIZE; r++) wt_mem[r] = $urandom;
      for (int v = 0; v < 256; v++) in_mem[v] = $urandom;
   endtask

   // Issue one job at the current cycle (T0) and build its expectations.
   task automatic run_job(input int nv, input bit reuse, input bit do_rst);
      int t0, f0, tdone;
      bit skip;
      logic [AWID-1:0] row, vec;
      t0   = cyc;
      skip = 1'b0;
`ifdef MMU_SEQ_WT_REUSE_EN
      skip = reuse && model_loaded;
`endif
      f0    = skip ? t0 + 2 : t0 + SIZE + 2;
      tdone = f0 + OUT_LAT + nv;
      if (!skip) for (int r = 0; r < SIZE; r++) q_wt.push_back('{t0 + 2 + r, 64'(wt_mem[r])});
      for (int t = f0; t <= f0 + nv + SIZE - 2; t++) begin
         row = '0;
         for (int j = 0; j < SIZE; j++) begin
            int v = t - f0 - j;
            if (v >= 0 && v < nv) begin
               vec = in_mem[v];
               row[j*BW +: BW] = vec[j*BW +: BW];
            end
         end
         q_dat.push_back('{t, 64'(row)});
      end
      for (int v = 0; v < nv; v++) q_out.push_back('{f0 + OUT_LAT + v, 64'(v)});
      q_done.push_back('{tdone, 64'(0)});
      for (int t = t0 + 1; t <= tdone; t++) exp_busy[t] = 1'b1;
      if (!skip) model_loaded = 1'b1;

      start = 1'b1; num_vec = VEC_W'(nv);
`ifdef MMU_SEQ_WT_REUSE_EN
      wt_reuse = reuse;
`endif
      tick();
      start = 1'b0; num_vec = VEC_W'($urandom);
      tick(); tick();
      start = 1'b1; num_vec = VEC_W'($urandom_range(1, 255));  // must be ignored
      tick();
      start = 1'b0;
      if (do_rst) begin
         while (cyc < f0 + 2) tick();
         q_wt.delete(); q_dat.delete(); q_out.delete(); q_done.delete();
         for (int t = cyc; t <= tdone; t++) exp_busy.delete(t);
         rst = 1'b1;
         tick(); tick();
         rst = 1'b0;
         model_loaded = 1'b0;
      end else begin
         while (cyc <= tdone) tick();
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      fill_mem();
      tick(); tick();
      rst = 1'b0;
      tick();

      wt_mem[0] = 32'h05020304; wt_mem[1] = 32'h03010203;
      wt_mem[2] = 32'h07040102; wt_mem[3] = 32'h01020403;
      in_mem[0] = 32'h00000201; in_mem[1] = 32'h00010101;
      in_mem[2] = 32'h00020302; in_mem[3] = 32'h00000104;
      run_job(4, 1'b0, 1'b0);

      start = 1'b1; num_vec = '0;     // zero-length job is dropped
      tick();
      start = 1'b0;
      repeat (4) tick();

      for (int k = 0; k < 6; k++) begin
         fill_mem();
         run_job($urandom_range(1, 12), 1'b0, 1'b0);
         if (k == 2) repeat (3) tick();
      end

      fill_mem();
      run_job(5, 1'b0, 1'b1);
      repeat (2) tick();
      fill_mem();
      run_job(6, 1'b0, 1'b0);

`ifdef MMU_SEQ_WT_REUSE_EN
      run_job(3, 1'b1, 1'b0);
      for (int v = 0; v < 256; v++) in_mem[v] = $urandom;
      run_job(4, 1'b1, 1'b0);
      run_job(3, 1'b1, 1'b1);
      repeat (2) tick();
      run_job(4, 1'b1, 1'b0);
`endif

      fill_mem();
      run_job(255, 1'b0, 1'b0);
      repeat (5) tick();

      chk("wt_queue_drained", q_wt.size(), 0);
      chk("data_queue_drained", q_dat.size(), 0);
      chk("out_queue_drained", q_out.size(), 0);
      chk("done_queue_drained", q_done.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
